// File: rtl/flash_fetch_arbiter.sv
`timescale 1ns / 1ps
// flash_fetch_arbiter
// Shares one SPI-flash word reader between the instruction-fetch port and the
// load/data port. Arbitrates between them, sequences mem_start/mem_done, returns
// 32-bit words, and keeps a one-entry last-word buffer so a repeated read of the
// same address is answered without going to flash.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   ifetch_req/addr/ack/data  instruction port: level request, one-cycle ack with data
//   dload_req/addr/ack/data   data port: level request, one-cycle ack with data
//   flush                     invalidates the last-word buffer
//   mem_start/addr            start pulse and target address towards mem_read
//   mem_data/done             word and completion strobe from mem_read
//   busy                      high whenever the arbiter is not idle
module flash_fetch_arbiter #(
    parameter int unsigned ADDR_W        = 24,
    parameter int unsigned DATA_W        = 32,
    parameter bit          DATA_PRIORITY = 1'b1,
    parameter bit          HIT_BUF_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifetch_req,
    input  logic [ADDR_W-1:0] ifetch_addr,
    output logic              ifetch_ack,
    output logic [DATA_W-1:0] ifetch_data,
    input  logic              dload_req,
    input  logic [ADDR_W-1:0] dload_addr,
    output logic              dload_ack,
    output logic [DATA_W-1:0] dload_data,
    input  logic              flush,
    output logic              mem_start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_done,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;            // 1: dload owns the transaction
    logic                last_grant_q, last_grant_d;  // 1: dload was granted last
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]   buf_tag_q, buf_tag_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [DATA_W-1:0]   ifetch_data_q, ifetch_data_d;
    logic [DATA_W-1:0]   dload_data_q, dload_data_d;

    logic                pick_dload;
    logic [ADDR_W-1:0]   req_addr;
    logic                hit;

    // On a tie: fixed data priority, or the port that was not granted last.
    assign pick_dload = (ifetch_req && dload_req) ?
                        (DATA_PRIORITY ? 1'b1 : !last_grant_q) : dload_req;
    assign req_addr   = pick_dload ? dload_addr : ifetch_addr;
    // A flush in the same cycle already counts as invalidating, so no stale hit.
    assign hit        = HIT_BUF_EN && buf_valid_q && !flush && (req_addr == buf_tag_q);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        addr_d        = addr_q;
        buf_valid_d   = buf_valid_q;
        buf_tag_d     = buf_tag_q;
        buf_data_d    = buf_data_q;
        ifetch_data_d = ifetch_data_q;
        dload_data_d  = dload_data_q;

        unique case (state_q)
            StIdle: begin
                if (ifetch_req || dload_req) begin
                    grant_d      = pick_dload;
                    last_grant_d = pick_dload;
                    addr_d       = req_addr;
                    if (hit) begin
                        state_d = StResp;
                        if (pick_dload) dload_data_d  = buf_data_q;
                        else            ifetch_data_d = buf_data_q;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (mem_done) begin
                    state_d = StResp;
                    if (grant_q) dload_data_d  = mem_data;
                    else         ifetch_data_d = mem_data;
                    if (HIT_BUF_EN) begin
                        buf_tag_d   = addr_q;
                        buf_data_d  = mem_data;
                        buf_valid_d = 1'b1;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Flush overrides any buffer fill in the same cycle.
        if (flush) buf_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b0;
            addr_q        <= '0;
            buf_valid_q   <= 1'b0;
            buf_tag_q     <= '0;
            buf_data_q    <= '0;
            ifetch_data_q <= '0;
            dload_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            addr_q        <= addr_d;
            buf_valid_q   <= buf_valid_d;
            buf_tag_q     <= buf_tag_d;
            buf_data_q    <= buf_data_d;
            ifetch_data_q <= ifetch_data_d;
            dload_data_q  <= dload_data_d;
        end
    end

    assign mem_start   = (state_q == StStart);
    assign mem_addr    = addr_q;
    assign busy        = (state_q != StIdle);
    assign ifetch_ack  = (state_q == StResp) && !grant_q;
    assign dload_ack   = (state_q == StResp) && grant_q;
    assign ifetch_data = ifetch_data_q;
    assign dload_data  = dload_data_q;

endmodule

// File: tb/tb_flash_fetch_arbiter.sv
`timescale 1ns / 1ps
// tb_flash_fetch_arbiter
// Scoreboard bench: each test pushes the expected (port, data) of every ack it
// provokes; monitors pop and compare whenever an ack appears. A second instance
// with round-robin ties covers the alternate arbitration mode.
module tb_flash_fetch_arbiter;

    typedef struct {
        logic        port;  // 1: dload
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifetch_req = 1'b0, dload_req = 1'b0, flush = 1'b0;
    logic [23:0] ifetch_addr = '0, dload_addr = '0;
    logic        ifetch_ack, dload_ack, mem_start, busy;
    logic [31:0] ifetch_data, dload_data, mem_data;
    logic [23:0] mem_addr;
    logic        mem_done;

    // Flash stimulus: automatic responder and manual pulses, merged.
    logic        flash_auto = 1'b1;
    logic        auto_done = 1'b0, man_done = 1'b0;
    logic [31:0] auto_data = '0, man_data = '0;
    assign mem_done = auto_done | man_done;
    assign mem_data = man_done ? man_data : auto_data;

    // Round-robin instance.
    logic        rr_ifetch_req = 1'b0, rr_dload_req = 1'b0;
    logic        rr_ifetch_ack, rr_dload_ack, rr_start, rr_busy;
    logic [31:0] rr_ifetch_data, rr_dload_data;
    logic [23:0] rr_addr;
    logic        rr_done = 1'b0;
    logic [31:0] rr_data = '0;

    int   n_pass = 0, n_total = 0, cyc = 0, start_cnt = 0;
    exp_t exp_q[$];
    exp_t exp_rr[$];

    flash_fetch_arbiter #(.ADDR_W(24), .DATA_W(32), .DATA_PRIORITY(1'b1), .HIT_BUF_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
        .ifetch_ack(ifetch_ack), .ifetch_data(ifetch_data),
        .dload_req(dload_req), .dload_addr(dload_addr),
        .dload_ack(dload_ack), .dload_data(dload_data),
        .flush(flush), .mem_start(mem_start), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_done(mem_done), .busy(busy)
    );

    flash_fetch_arbiter #(.ADDR_W(24), .DATA_W(32), .DATA_PRIORITY(1'b0), .HIT_BUF_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .ifetch_req(rr_ifetch_req), .ifetch_addr(ifetch_addr),
        .ifetch_ack(rr_ifetch_ack), .ifetch_data(rr_ifetch_data),
        .dload_req(rr_dload_req), .dload_addr(dload_addr),
        .dload_ack(rr_dload_ack), .dload_data(rr_dload_data),
        .flush(flush), .mem_start(rr_start), .mem_addr(rr_addr),
        .mem_data(rr_data), .mem_done(rr_done), .busy(rr_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_start) start_cnt <= start_cnt + 1;

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        return (a == 24'h000100) ? 32'hDEADBEEF : (32'hC0DE0000 ^ {8'h00, a});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(input string name, output int c);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_start) seen = 1'b1;
        end
        c = cyc;
        check({name, "_start_seen"}, {63'b0, seen}, 64'd1);
    endtask

    task automatic wait_ack(input string name, input logic port, output int c);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (port ? dload_ack : ifetch_ack) seen = 1'b1;
        end
        c = cyc;
        check({name, "_ack_seen"}, {63'b0, seen}, 64'd1);
    endtask

    task automatic wait_rr(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rr_ifetch_ack || rr_dload_ack) seen = 1'b1;
        end
        check({name, "_ack_seen"}, {63'b0, seen}, 64'd1);
    endtask

    // Monitor for the data-priority instance.
    always @(negedge clk) begin
        exp_t e;
        if (ifetch_ack || dload_ack) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: ifetch_ack=%b dload_ack=%b, required no ack",
                         ifetch_ack, dload_ack);
            end else begin
                e = exp_q.pop_front();
                check("ack_one_hot", {63'b0, ifetch_ack && dload_ack}, 64'd0);
                check("ack_port", {63'b0, dload_ack}, {63'b0, e.port});
                check("ack_data", {32'b0, dload_ack ? dload_data : ifetch_data}, {32'b0, e.data});
            end
        end
    end

    // Monitor for the round-robin instance.
    always @(negedge clk) begin
        exp_t e;
        if (rr_ifetch_ack || rr_dload_ack) begin
            if (exp_rr.size() == 0) begin
                n_total++;
                $display("FAIL rr_unexpected_ack: ifetch_ack=%b dload_ack=%b, required no ack",
                         rr_ifetch_ack, rr_dload_ack);
            end else begin
                e = exp_rr.pop_front();
                check("rr_ack_port", {63'b0, rr_dload_ack}, {63'b0, e.port});
                check("rr_ack_data", {32'b0, rr_dload_ack ? rr_dload_data : rr_ifetch_data},
                      {32'b0, e.data});
            end
        end
    end

    // Automatic flash model: mem_done five cycles after mem_start.
    initial begin
        logic [23:0] a;
        forever begin
            @(negedge clk);
            if (flash_auto && mem_start) begin
                a = mem_addr;
                repeat (5) @(posedge clk);
                #1;
                auto_done = 1'b1;
                auto_data = flash_word(a);
                @(posedge clk);
                #1;
                auto_done = 1'b0;
            end
        end
    end

    // Flash model for the round-robin instance: mem_done one cycle after start.
    initial begin
        logic [23:0] a;
        forever begin
            @(negedge clk);
            if (rr_start) begin
                a = rr_addr;
                @(posedge clk);
                #1;
                rr_done = 1'b1;
                rr_data = flash_word(a);
                @(posedge clk);
                #1;
                rr_done = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1);
    end

    initial begin
        int c0, c1, k, s0;
        exp_t e;

        // Reset held two cycles; everything low; stray mem_done ignored.
        step();
        step();
        @(negedge clk);
        check("rst_ifetch_ack", {63'b0, ifetch_ack}, 64'd0);
        check("rst_dload_ack", {63'b0, dload_ack}, 64'd0);
        check("rst_ifetch_data", {32'b0, ifetch_data}, 64'd0);
        check("rst_dload_data", {32'b0, dload_data}, 64'd0);
        check("rst_mem_start", {63'b0, mem_start}, 64'd0);
        check("rst_mem_addr", {40'b0, mem_addr}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        step();
        rst = 1'b0;
        step();
        man_data = 32'h11111111;
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("idle_done_busy", {63'b0, busy}, 64'd0);
        check("idle_done_no_start", start_cnt, 64'd0);

        // Fetch miss.
        step();
        s0 = start_cnt;
        push(1'b0, 32'hDEADBEEF);
        ifetch_addr = 24'h000100;
        ifetch_req  = 1'b1;
        wait_start("miss", c0);
        check("miss_mem_addr", {40'b0, mem_addr}, 64'h100);
        wait_ack("miss", 1'b0, c1);
        check("miss_latency", c1, c0 + 6);
        step();
        ifetch_req = 1'b0;
        repeat (2) step();
        check("miss_one_start", start_cnt - s0, 64'd1);

        // Buffer hit on the same address, then a data miss.
        s0 = start_cnt;
        push(1'b0, 32'hDEADBEEF);
        ifetch_req = 1'b1;
        k = cyc;
        wait_ack("hit", 1'b0, c1);
        check("hit_latency", c1, k + 1);
        step();
        ifetch_req = 1'b0;
        step();
        check("hit_no_start", start_cnt - s0, 64'd0);
        push(1'b1, 32'hC0DE0104);
        dload_addr = 24'h000104;
        dload_req  = 1'b1;
        wait_start("dmiss", c0);
        check("dmiss_mem_addr", {40'b0, mem_addr}, 64'h104);
        wait_ack("dmiss", 1'b1, c1);
        step();
        dload_req = 1'b0;
        step();
        check("dmiss_one_start", start_cnt - s0, 64'd1);

        // Contention with data priority: dload four times, then ifetch.
        s0 = start_cnt;
        repeat (4) push(1'b1, 32'hC0DE0020);
        push(1'b0, 32'hC0DE0010);
        ifetch_addr = 24'h000010;
        dload_addr  = 24'h000020;
        ifetch_req  = 1'b1;
        dload_req   = 1'b1;
        for (int r = 0; r < 4; r++) wait_ack("prio_d", 1'b1, c1);
        step();
        dload_req = 1'b0;
        wait_ack("prio_i", 1'b0, c1);
        step();
        ifetch_req = 1'b0;
        step();
        check("prio_starts", start_cnt - s0, 64'd2);

        // Contention with round-robin ties: dload, ifetch, dload, ifetch.
        for (int r = 0; r < 2; r++) begin
            e.port = 1'b1; e.data = 32'hC0DE0020; exp_rr.push_back(e);
            e.port = 1'b0; e.data = 32'hC0DE0010; exp_rr.push_back(e);
        end
        rr_ifetch_req = 1'b1;
        rr_dload_req  = 1'b1;
        for (int r = 0; r < 4; r++) wait_rr("rr");
        step();
        rr_ifetch_req = 1'b0;
        rr_dload_req  = 1'b0;
        repeat (2) step();
        check("rr_idle", {63'b0, rr_busy}, 64'd0);

        // Flush coinciding with mem_done: ack still delivered, buffer left invalid.
        flash_auto = 1'b0;
        push(1'b0, 32'h12345678);
        ifetch_addr = 24'h000200;
        ifetch_req  = 1'b1;
        wait_start("flush", c0);
        check("flush_mem_addr", {40'b0, mem_addr}, 64'h200);
        step();
        step();
        man_data = 32'h12345678;
        man_done = 1'b1;
        flush    = 1'b1;
        step();
        man_done = 1'b0;
        flush    = 1'b0;
        wait_ack("flush", 1'b0, c1);
        step();
        ifetch_req = 1'b0;
        flash_auto = 1'b1;
        step();
        s0 = start_cnt;
        push(1'b0, 32'hC0DE0200);
        ifetch_req = 1'b1;
        wait_ack("flush_refetch", 1'b0, c1);
        step();
        ifetch_req = 1'b0;
        step();
        check("flush_refetch_miss", start_cnt - s0, 64'd1);

        // Reset while waiting on flash; the late mem_done must be ignored.
        flash_auto = 1'b0;
        dload_addr = 24'h000300;
        dload_req  = 1'b1;
        wait_start("rstwait", c0);
        step();
        rst       = 1'b1;
        dload_req = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstwait_busy", {63'b0, busy}, 64'd0);
        check("rstwait_no_ack", {63'b0, dload_ack}, 64'd0);
        step();
        step();
        man_data = 32'hBAD0BAD0;
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("late_done_busy", {63'b0, busy}, 64'd0);
        flash_auto = 1'b1;
        step();
        s0 = start_cnt;
        push(1'b1, 32'hC0DE0300);
        dload_req = 1'b1;
        wait_ack("rstwait_refetch", 1'b1, c1);
        step();
        dload_req = 1'b0;
        step();
        check("rstwait_buf_invalid", start_cnt - s0, 64'd1);

        repeat (3) step();
        check("sb_drained", exp_q.size(), 64'd0);
        check("rr_sb_drained", exp_rr.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
